rr_arb3_ctrl: RTL
=================

RR_ARB3_CTRL -- requirements
Module: rr_arb3_ctrl

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8: maximum consecutive grant cycles per owner, legal range 0..255, 0 = no timeout.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port RSTB  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports REQ1, REQ2, REQ3  input  1 each  request for the shared resource from requesters 1..3.
REQ-005 SHALL have port DONE  input  1  current owner releases the resource.
REQ-006 SHALL have ports GNT1, GNT2, GNT3  output  1 each  registered grants, at most one high at a time.
REQ-007 SHALL have port IDLEN  output  1  combinational NOR of GNT1, GNT2, GNT3; 1 when no grant is active.
REQ-008 SHALL have port TOUT  output  1  registered one-cycle pulse marking a timeout release.

Function
REQ-009 SHALL implement states IDLE, GRANT and GAP, plus a 2-bit last-owner pointer LAST (values 1..3) and an 8-bit hold counter CNT.
REQ-010 In IDLE or GAP with any REQx=1 sampled, SHALL enter GRANT, set the winner's GNT on that edge and clear CNT to 0.
REQ-011 Winner SHALL be the first requesting index in circular order LAST+1, LAST+2, LAST (3 wraps to 1).
REQ-012 In IDLE with no request sampled, SHALL remain in IDLE with all grants 0.
REQ-013 GAP SHALL last exactly one cycle with all grants 0, then arbitrate as IDLE does; with no request it SHALL go to IDLE.
REQ-014 In GRANT, CNT SHALL increment by 1 per cycle and saturate at 255, never wrapping.
REQ-015 In GRANT, the edge that samples DONE=1, owner REQx=0, or (HOLD_MAX!=0 and CNT==HOLD_MAX-1) SHALL clear the grant, load LAST with the owner index and enter GAP.
REQ-016 Grant latency: GNTx SHALL rise on the first edge sampling REQx=1 in IDLE or GAP (1 cycle).
REQ-017 With HOLD_MAX=N>0, an owner SHALL hold its grant for at most N consecutive cycles.
REQ-018 TOUT SHALL be 1 during the GAP cycle only if that release was caused solely by the timeout condition; otherwise 0.
REQ-019 DONE and timeout on the same edge SHALL be treated as a DONE release, with TOUT=0.
REQ-020 DONE sampled outside GRANT SHALL be ignored.
REQ-021 Request changes by non-owners during GRANT SHALL NOT affect the current grant.
REQ-022 HOLD_MAX=1 SHALL give single-cycle grants separated by one GAP cycle.
REQ-023 Back-to-back minimum: release edge, one GAP cycle, next GNT on the following edge, so there is one dead cycle between owners.
REQ-024 Outputs SHALL never show two grants high in any cycle, including the reset-exit cycle.

Reset
REQ-025 RSTB=0 SHALL asynchronously force state IDLE, GNT1..3=0, TOUT=0, CNT=0 and LAST=3, so that REQ1 has first priority.
REQ-026 IDLEN SHALL read 1 throughout reset.
REQ-027 Reset asserted mid-grant SHALL drop the grant immediately without waiting for a clock edge.
REQ-028 After RSTB deasserts, the first edge SHALL arbitrate normally.

Verification
REQ-029 Reset, then REQ1..3=1 and DONE pulsed in each grant: grant order SHALL be 1,2,3,1 with one GAP cycle between grants.
REQ-030 HOLD_MAX=4, REQ2 held, DONE=0: GNT2 SHALL be high exactly 4 cycles, then TOUT=1 for one cycle, then GNT2 SHALL regrant (sole requester).
REQ-031 HOLD_MAX=4, DONE=1 on the 4th grant cycle: TOUT SHALL stay 0.
REQ-032 Owner drops REQ3 mid-grant while REQ1=1: GNT3 SHALL fall on the next edge, then one GAP cycle, then GNT1=1.
REQ-033 RSTB pulsed low during GNT2: all grants SHALL go 0 asynchronously; after release with REQ1..3=1, GNT1 SHALL be granted first.
REQ-034 HOLD_MAX=0, REQ1 held 300 cycles: GNT1 SHALL stay 1 with TOUT=0 and CNT saturated at 255.

Source files
------------

// File: rtl/rr_arb3_ctrl.sv
// Three-way round-robin arbiter with per-owner hold timeout.
// One dead GAP cycle always separates consecutive owners.
module rr_arb3_ctrl #(
  parameter int HOLD_MAX = 8
) (
  input  logic CLK,
  input  logic RSTB,
  input  logic REQ1,
  input  logic REQ2,
  input  logic REQ3,
  input  logic DONE,
  output logic GNT1,
  output logic GNT2,
  output logic GNT3,
  output logic IDLEN,
  output logic TOUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST  = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);
  localparam logic       TIMEOUT_EN = (HOLD_MAX != 0);

  state_e      state_q, state_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tout_q, tout_d;

  logic [2:0]  req_vec;
  logic [2:0]  winner;
  logic [1:0]  owner_idx;
  logic        owner_req;
  logic        timeout;

  // Search order starts just after the last owner and ends on it.
  function automatic logic [2:0] pick_winner(input logic [1:0] last, input logic [2:0] req);
    logic [2:0] win;
    win = 3'b000;
    case (last)
      2'd1: begin
        if (req[1])      win = 3'b010;
        else if (req[2]) win = 3'b100;
        else if (req[0]) win = 3'b001;
      end
      2'd2: begin
        if (req[2])      win = 3'b100;
        else if (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
      end
      default: begin
        if (req[0])      win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
      end
    endcase
    return win;
  endfunction

  assign req_vec   = {REQ3, REQ2, REQ1};
  assign winner    = pick_winner(last_q, req_vec);
  assign owner_idx = gnt_q[2] ? 2'd3 : (gnt_q[1] ? 2'd2 : 2'd1);
  assign owner_req = |(gnt_q & req_vec);
  assign timeout   = TIMEOUT_EN && (cnt_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        gnt_d = winner;
        if (|winner) begin
          state_d = GRANT;
          cnt_d   = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // DONE wins over a simultaneous timeout, so TOUT flags pure timeouts only.
        if (DONE || !owner_req || timeout) begin
          gnt_d   = 3'b000;
          last_d  = owner_idx;
          state_d = GAP;
          tout_d  = timeout && !DONE && owner_req;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      last_q  <= 2'd3;
      cnt_q   <= 8'd0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
    end
  end

  assign GNT1  = gnt_q[0];
  assign GNT2  = gnt_q[1];
  assign GNT3  = gnt_q[2];
  assign IDLEN = ~(|gnt_q);
  assign TOUT  = tout_q;

endmodule
